// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the key-driven clock-enable controller.
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms of stable key level at 27 MHz
//   DEFAULT_BURST_CYCLES    : 1 s burst length at 27 MHz (burst build only)
//   mode_e                  : encoding of the mode_i pin
package key_ctrl_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;
  localparam int DEFAULT_BURST_CYCLES    = 27000000;

  typedef enum logic {
    MODE_HOLD   = 1'b0,
    MODE_TOGGLE = 1'b1
  } mode_e;

endpackage

// File: rtl/key_debounce.sv
// Synchroniser and debouncer for an asynchronous, active-low push key.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   key_i       : raw key, active-low, asynchronous to clk
//   key_db_o    : debounced key level, registered
//   press_o     : registered one-cycle pulse, the cycle after key_db_o falls
//   press_d_o   : next-state of press_o, so a consumer can register its own
//                 reaction on the same edge that press_o rises
module key_debounce
  import key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic key_db_o,
  output logic press_o,
  output logic press_d_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             key_db_q;
  logic             key_db_d;
  logic             key_db_dly_q;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreement (a bounce back) drops it to zero, so a new
  // level is accepted only after DEBOUNCE_CYCLES uninterrupted samples. The
  // acceptance clears the counter, so it never goes beyond CNT_MAX.
  always_comb begin
    cnt_d    = '0;
    key_db_d = key_db_q;
    if (sync2_q != key_db_q) begin
      if (cnt_q == CNT_MAX) begin
        key_db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Falling edge of the accepted level, seen one register stage late.
  assign press_d = key_db_dly_q & ~key_db_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      key_db_q     <= 1'b1;
      key_db_dly_q <= 1'b1;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= key_i;
      sync2_q      <= sync1_q;
      key_db_q     <= key_db_d;
      key_db_dly_q <= key_db_q;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign key_db_o  = key_db_q;
  assign press_o   = press_q;
  assign press_d_o = press_d;

endmodule

// File: rtl/key_clk_gate_ctrl.sv
// Clock-enable controller for the DHCEN gate in front of the divider chain.
// A raw push key is synchronised and debounced, then turned into a
// registered, glitch-free enable level.
//   mode_i = 0 : hold   - ce_o follows the key (pressed = clock runs)
//   mode_i = 1 : toggle - each debounced press flips ce_o
// Optional build macro KEYCE_BURST_EN: mode_i = 1 becomes burst mode, where a
// press holds ce_o high for BURST_CYCLES cycles (a press during a burst
// restarts it without a gap).
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   key_i     : raw key, active-low, asynchronous
//   mode_i    : mode select, quasi-static
//   ce_o      : registered clock enable for DHCEN CE
//   key_db_o  : debounced key level, active-low
//   press_o   : one-cycle pulse per debounced press
module key_clk_gate_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter logic CE_RESET        = 1'b1
`ifdef KEYCE_BURST_EN
  ,
  parameter int   BURST_CYCLES    = DEFAULT_BURST_CYCLES
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic mode_i,
  output logic ce_o,
  output logic key_db_o,
  output logic press_o
);

  logic  key_db;
  logic  press_d;
  logic  ce_q;
  logic  ce_d;
  mode_e mode;

  assign mode = mode_e'(mode_i);

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .key_i     (key_i),
    .key_db_o  (key_db),
    .press_o   (press_o),
    .press_d_o (press_d)
  );

`ifdef KEYCE_BURST_EN
  localparam int               BURST_W   = $clog2(BURST_CYCLES);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST_CYCLES - 1);

  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] burst_d;

  // In burst mode ce_o is high while the counter is non-zero and for the one
  // cycle in which it reaches zero, giving exactly BURST_CYCLES high cycles.
  // Acting on press_d (rather than press_o) lets ce_o move on the same edge
  // that press_o rises; a press on the last burst cycle reloads seamlessly.
  always_comb begin
    ce_d    = ce_q;
    burst_d = '0;
    if (mode == MODE_HOLD) begin
      ce_d = ~key_db;
    end else if (press_d) begin
      ce_d    = 1'b1;
      burst_d = BURST_MAX;
    end else if (burst_q != '0) begin
      ce_d    = 1'b1;
      burst_d = burst_q - 1'b1;
    end else begin
      ce_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  // Mode is evaluated combinationally each cycle, so a press coinciding with a
  // mode change follows the new mode, and leaving toggle for hold adopts the
  // key level on the very next edge.
  always_comb begin
    ce_d = ce_q;
    if (mode == MODE_HOLD) begin
      ce_d = ~key_db;
    end else if (press_d) begin
      ce_d = ~ce_q;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q <= CE_RESET;
    end else begin
      ce_q <= ce_d;
    end
  end

  assign ce_o     = ce_q;
  assign key_db_o = key_db;

endmodule

// File: tb/tb_key_clk_gate_ctrl.sv
module tb_key_clk_gate_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic key_i;
  logic mode_i;
  logic ce_o;
  logic key_db_o;
  logic press_o;

  always #5 clk = ~clk;

`ifdef KEYCE_BURST_EN
  key_clk_gate_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CE_RESET        (1'b1),
    .BURST_CYCLES    (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_i    (key_i),
    .mode_i   (mode_i),
    .ce_o     (ce_o),
    .key_db_o (key_db_o),
    .press_o  (press_o)
  );
`else
  key_clk_gate_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CE_RESET        (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_i    (key_i),
    .mode_i   (mode_i),
    .ce_o     (ce_o),
    .key_db_o (key_db_o),
    .press_o  (press_o)
  );
`endif

  typedef struct {
    int    cyc;
    logic  ce;
    logic  db;
    logic  pr;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  logic model_ce = 1'b0;

  task automatic chk(string tag, logic obs, logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected outputs at edge (now + rel), queued at stimulus time.
  task automatic push(int rel, logic ce, logic db, logic pr, string tag);
    exp_t e;
    e.cyc = cyc + rel;
    e.ce  = ce;
    e.db  = db;
    e.pr  = pr;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Advance n edges; sample 1 time unit after each edge and retire due entries.
  task automatic run(int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk($sformatf("%s_ce@%0d", e.tag, e.cyc), ce_o, e.ce);
        chk($sformatf("%s_db@%0d", e.tag, e.cyc), key_db_o, e.db);
        chk($sformatf("%s_pr@%0d", e.tag, e.cyc), press_o, e.pr);
      end
    end
  endtask

  // Key goes low and is held: db falls at edge 6, press and new ce at edge 7.
  task automatic press(logic ce_after, string tag);
    $display("[TB] cyc %0d press (%s) ce %b -> %b", cyc, tag, model_ce, ce_after);
    key_i = 1'b0;
    for (int r = 1; r <= 20; r++) begin
      push(r, (r >= 7) ? ce_after : model_ce, (r >= 6) ? 1'b0 : 1'b1,
           (r == 7) ? 1'b1 : 1'b0, tag);
    end
    run(20);
    model_ce = ce_after;
  endtask

  // Key released: db rises at edge 6, ce (if it changes) at edge 7, no pulse.
  task automatic release_key(logic ce_after, string tag);
    $display("[TB] cyc %0d release (%s) ce %b -> %b", cyc, tag, model_ce, ce_after);
    key_i = 1'b1;
    for (int r = 1; r <= 12; r++) begin
      push(r, (r >= 7) ? ce_after : model_ce, (r >= 6) ? 1'b1 : 1'b0, 1'b0, tag);
    end
    run(12);
    model_ce = ce_after;
  endtask

  // Reset asserted mid-cycle; outputs must respond before any clock edge.
  task automatic async_reset(string tag);
    $display("[TB] cyc %0d async reset (%s)", cyc, tag);
    #3;
    rst = 1'b1;
    #1;
    chk({tag, "_ce"}, ce_o, 1'b1);
    chk({tag, "_db"}, key_db_o, 1'b1);
    chk({tag, "_pr"}, press_o, 1'b0);
    run(1);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    key_i  = 1'b1;
    mode_i = 1'b0;
    run(3);
    chk("rst_ce", ce_o, 1'b1);
    chk("rst_db", key_db_o, 1'b1);
    chk("rst_pr", press_o, 1'b0);
    rst = 1'b0;

    // Hold mode with key released: enable drops on the first edge.
    push(1, 1'b0, 1'b1, 1'b0, "post_rst");
    push(2, 1'b0, 1'b1, 1'b0, "post_rst");
    run(2);
    model_ce = 1'b0;

    // Hold press, then reset while pressed; the press is re-debounced from scratch.
    press(1'b1, "hold_press");
    async_reset("rst_pressed");
    model_ce = 1'b0;
    press(1'b1, "hold_repress");
    release_key(1'b0, "hold_release");

    // Bounce: 3 low, 1 high, 3 low, then high; never accepted.
    $display("[TB] cyc %0d bounce burst", cyc);
    for (int r = 1; r <= 15; r++) push(r, 1'b0, 1'b1, 1'b0, "bounce");
    key_i = 1'b0; run(3);
    key_i = 1'b1; run(1);
    key_i = 1'b0; run(3);
    key_i = 1'b1; run(8);

`ifndef KEYCE_BURST_EN
    // Hold -> toggle keeps ce; each press flips it, releases do nothing.
    $display("[TB] cyc %0d mode hold->toggle", cyc);
    mode_i = 1'b1;
    push(1, 1'b0, 1'b1, 1'b0, "to_toggle");
    push(2, 1'b0, 1'b1, 1'b0, "to_toggle");
    run(2);
    press(1'b1, "tog1");       release_key(1'b1, "tog1_rel");
    press(1'b0, "tog2");       release_key(1'b0, "tog2_rel");
    press(1'b1, "tog3");       release_key(1'b1, "tog3_rel");
    press(1'b0, "tog4");       release_key(1'b0, "tog4_rel");

    // Toggle -> hold with key released: ce stays 0.
    $display("[TB] cyc %0d mode toggle->hold", cyc);
    mode_i = 1'b0;
    for (int r = 1; r <= 3; r++) push(r, 1'b0, 1'b1, 1'b0, "to_hold");
    run(3);
    press(1'b1, "ms_press");

    // Hold -> toggle while pressed: ce holds 1, release leaves it at 1.
    $display("[TB] cyc %0d mode hold->toggle pressed", cyc);
    mode_i = 1'b1;
    for (int r = 1; r <= 3; r++) push(r, 1'b1, 1'b0, 1'b0, "to_toggle_pr");
    run(3);
    release_key(1'b1, "ms_release");

    // Toggle -> hold with key released: ce adopts ~key_db on the next edge.
    $display("[TB] cyc %0d mode toggle->hold ce=1", cyc);
    mode_i = 1'b0;
    push(1, 1'b0, 1'b1, 1'b0, "to_hold_adopt");
    push(2, 1'b0, 1'b1, 1'b0, "to_hold_adopt");
    run(2);
    model_ce = 1'b0;
`endif

    async_reset("rst_ce_low");
    push(1, 1'b0, 1'b1, 1'b0, "post_rst2");
    push(2, 1'b0, 1'b1, 1'b0, "post_rst2");
    run(2);

`ifdef KEYCE_BURST_EN
    // Burst: press at edge 7 gives 8 high cycles; a second press landing on the
    // last burst cycle (edge 15) reloads with no gap, so ce falls at edge 23.
    $display("[TB] cyc %0d burst with reload", cyc);
    mode_i = 1'b1;
    for (int r = 1; r <= 30; r++) begin
      push(r, (r >= 7 && r <= 22) ? 1'b1 : 1'b0,
           (r < 6) ? 1'b1 : (r < 10) ? 1'b0 : (r < 14) ? 1'b1 : 1'b0,
           (r == 7 || r == 15) ? 1'b1 : 1'b0, "burst");
    end
    key_i = 1'b0; run(4);
    key_i = 1'b1; run(4);
    key_i = 1'b0; run(22);
    key_i = 1'b1;
`endif

    chk("sb_drained", (exp_q.size() == 0) ? 1'b1 : 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
